// File: rtl/viterbi_acs_sched.sv
// BMC/ACS sequencing controller for the K=7 rate-1/2 Viterbi decoder.
// Optional path-metric normalization is enabled with `define ACS_NORM_EN.
module viterbi_acs_sched #(
  parameter  int NUM_STATES = 64,
  parameter  int NUM_UNITS  = 8,
  parameter  int DEC_DEPTH  = 64,
  parameter  int TB_LEN     = 32,
  localparam int GROUPS     = NUM_STATES / NUM_UNITS,
  localparam int GW         = $clog2(GROUPS),
  localparam int AW         = $clog2(DEC_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_valid_i,
  input  logic [1:0]    rx_pair_i,
  output logic          rx_ready_o,
  output logic [1:0]    bmc_rx_pair_o,
  output logic          acs_en_o,
  output logic [GW-1:0] acs_grp_o,
  output logic          pm_bank_sel_o,
  input  logic          acs_pm_msb_i,
  output logic          norm_en_o,
  output logic          dec_we_o,
  output logic [AW-1:0] dec_addr_o,
  input  logic          tb_busy_i,
  output logic          tb_start_o,
  output logic [AW-1:0] tb_addr_o
);
  localparam int SW = $clog2(TB_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic [AW-1:0]   dec_addr_q, tb_addr_q;
  logic [1:0]      pair_q;
  logic            rx_ready_q, acs_en_q, pm_sel_q, tb_pending_q, tb_start_q;
  logic            accept, commit, tb_req;

  assign accept = rx_ready_q & rx_valid_i;
  assign commit = (state_q == COMMIT);

  always_comb begin
    state_d = state_q;
    grp_d   = '0;
    case (state_q)
      IDLE:   if (accept) state_d = RUN;
      RUN: begin
        grp_d = grp_q + 1'b1;
        if (grp_q == GW'(GROUPS - 1)) begin
          state_d = COMMIT;
          grp_d   = '0;
        end
      end
      COMMIT: state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating step count; a request fires on every commit once saturated.
  assign steps_d = (steps_q == SW'(TB_LEN)) ? steps_q : steps_q + 1'b1;
  assign tb_req  = commit & (steps_d == SW'(TB_LEN));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grp_q        <= '0;
      steps_q      <= '0;
      dec_addr_q   <= '0;
      tb_addr_q    <= '0;
      pair_q       <= '0;
      rx_ready_q   <= 1'b0;
      acs_en_q     <= 1'b0;
      pm_sel_q     <= 1'b0;
      tb_pending_q <= 1'b0;
      tb_start_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      rx_ready_q <= (state_d != RUN);
      acs_en_q   <= (state_d == RUN);
      if (accept) pair_q <= rx_pair_i;
      if (commit) begin
        pm_sel_q   <= ~pm_sel_q;
        steps_q    <= steps_d;
        dec_addr_q <= (dec_addr_q == AW'(DEC_DEPTH - 1)) ? '0 : dec_addr_q + 1'b1;
      end
      if (tb_req) tb_addr_q <= dec_addr_q;
      tb_start_q   <= tb_pending_q & ~tb_busy_i;
      tb_pending_q <= tb_req | (tb_pending_q & tb_busy_i);
    end
  end

`ifdef ACS_NORM_EN
  logic norm_req_q, norm_arm_q, norm_arm_d, norm_en_q;

  // Overflow seen during step n arms normalization for all of step n+1.
  assign norm_arm_d = commit ? norm_req_q : norm_arm_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      norm_req_q <= 1'b0;
      norm_arm_q <= 1'b0;
      norm_en_q  <= 1'b0;
    end else begin
      norm_req_q <= commit ? 1'b0 : (norm_req_q | ((state_q == RUN) & acs_pm_msb_i));
      norm_arm_q <= norm_arm_d;
      norm_en_q  <= (state_d == RUN) & norm_arm_d;
    end
  end

  assign norm_en_o = norm_en_q;
`else
  logic unused_pm_msb;
  assign unused_pm_msb = acs_pm_msb_i;
  assign norm_en_o     = 1'b0;
`endif

  assign rx_ready_o    = rx_ready_q;
  assign bmc_rx_pair_o = pair_q;
  assign acs_en_o      = acs_en_q;
  assign acs_grp_o     = grp_q;
  assign pm_bank_sel_o = pm_sel_q;
  assign dec_we_o      = acs_en_q;
  assign dec_addr_o    = dec_addr_q;
  assign tb_start_o    = tb_start_q;
  assign tb_addr_o     = tb_addr_q;
endmodule
